// File: rtl/mux_scan_reg.sv
// mux_scan_reg: registered NCH-channel, W-bit multiplexer with a valid/ready
// output handshake, an auto-scan mode and out-of-range select detection.
//
// Ports:
//   CLK        clock, rising edge
//   RST_N      asynchronous active-low reset
//   ENA        capture enable
//   MODE       0 = manual select, 1 = auto-scan
//   Sel        manual channel select
//   Ch_Mask    scan-mode channel enables (bit i = channel i)
//   IN         channel data, channel i = IN[i*W +: W]
//   OUT_READY  downstream accepts the current beat
//   OUT_VALID  Output/Out_Ch hold a valid beat
//   Output     captured data
//   Out_Ch     channel index of the captured data
//   SEL_ERR    one-cycle pulse: manual Sel >= NCH on a capture attempt
module mux_scan_reg #(
  parameter int NCH   = 8,
  parameter int W     = 8,
  parameter int DWELL = 4,
  localparam int SELW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              ENA,
  input  logic              MODE,
  input  logic [SELW-1:0]   Sel,
  input  logic [NCH-1:0]    Ch_Mask,
  input  logic [NCH*W-1:0]  IN,
  input  logic              OUT_READY,
  output logic              OUT_VALID,
  output logic [W-1:0]      Output,
  output logic [SELW-1:0]   Out_Ch,
  output logic              SEL_ERR
);

  localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;

  logic [W-1:0]    data_q, data_d;
  logic [SELW-1:0] ch_q, ch_d;
  logic            valid_q, valid_d;
  logic            sel_err_q, sel_err_d;
  logic [SELW-1:0] ptr_q, ptr_d;
  logic [DW-1:0]   dwell_q, dwell_d;
  logic            mode_q;

  logic            mode_chg;
  logic            slot_free;
  logic            attempt;
  logic            sel_ok;
  logic            capture;
  logic [SELW-1:0] scan_ch;
  logic [SELW-1:0] cap_ch;

  // First set mask bit strictly after 'start', wrapping; with a single set
  // bit equal to 'start' the full-circle offset returns 'start' itself.
  function automatic logic [SELW-1:0] next_set(input logic [NCH-1:0] mask,
                                               input logic [SELW-1:0] start);
    logic [SELW-1:0] res;
    int idx;
    res = start;
    // Walk offsets from far to near so the nearest set bit is written last.
    for (int k = NCH; k >= 1; k--) begin
      idx = int'(start) + k;
      if (idx >= NCH) idx = idx - NCH;
      if (mask[idx]) res = SELW'(idx);
    end
    return res;
  endfunction

  always_comb begin
    mode_chg  = (MODE != mode_q);
    slot_free = !valid_q || OUT_READY;
    attempt   = ENA && slot_free && !mode_chg;
    sel_ok    = (int'(Sel) < NCH);
    scan_ch   = Ch_Mask[ptr_q] ? ptr_q : next_set(Ch_Mask, ptr_q);
    cap_ch    = MODE ? scan_ch : Sel;
    capture   = attempt && (MODE ? (|Ch_Mask) : sel_ok);

    data_d    = data_q;
    ch_d      = ch_q;
    valid_d   = valid_q && !OUT_READY;
    sel_err_d = attempt && !MODE && !sel_ok;
    ptr_d     = ptr_q;
    dwell_d   = dwell_q;

    if (capture) begin
      data_d  = IN[int'(cap_ch)*W +: W];
      ch_d    = cap_ch;
      valid_d = 1'b1;
    end

    // A mode change restarts the scan from channel 0 (lowest set bit).
    if (mode_chg) begin
      ptr_d   = '0;
      dwell_d = '0;
    end else if (capture && MODE) begin
      if (dwell_q == DW'(DWELL - 1)) begin
        dwell_d = '0;
        ptr_d   = next_set(Ch_Mask, scan_ch);
      end else begin
        dwell_d = dwell_q + 1'b1;
        ptr_d   = scan_ch;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      data_q    <= '0;
      ch_q      <= '0;
      valid_q   <= 1'b0;
      sel_err_q <= 1'b0;
      ptr_q     <= '0;
      dwell_q   <= '0;
      mode_q    <= 1'b0;
    end else begin
      data_q    <= data_d;
      ch_q      <= ch_d;
      valid_q   <= valid_d;
      sel_err_q <= sel_err_d;
      ptr_q     <= ptr_d;
      dwell_q   <= dwell_d;
      mode_q    <= MODE;
    end
  end

  assign OUT_VALID = valid_q;
  assign Output    = data_q;
  assign Out_Ch    = ch_q;
  assign SEL_ERR   = sel_err_q;

endmodule

// File: tb/tb_mux_scan_reg.sv
module tb_mux_scan_reg;

  logic CLK;
  logic RST_N;

  // 8-channel instance, DWELL=2
  logic        ena8, mode8, ready8;
  logic [2:0]  sel8;
  logic [7:0]  mask8;
  logic [63:0] in8;
  logic        valid8, err8;
  logic [7:0]  out8;
  logic [2:0]  ch8;

  // 6-channel instance for out-of-range select
  logic        ena6, mode6, ready6;
  logic [2:0]  sel6;
  logic [5:0]  mask6;
  logic [47:0] in6;
  logic        valid6, err6;
  logic [7:0]  out6;
  logic [2:0]  ch6;

  int total = 0;
  int bad   = 0;

  mux_scan_reg #(.NCH(8), .W(8), .DWELL(2)) dut8 (
    .CLK(CLK), .RST_N(RST_N), .ENA(ena8), .MODE(mode8), .Sel(sel8),
    .Ch_Mask(mask8), .IN(in8), .OUT_READY(ready8), .OUT_VALID(valid8),
    .Output(out8), .Out_Ch(ch8), .SEL_ERR(err8)
  );

  mux_scan_reg #(.NCH(6), .W(8), .DWELL(4)) dut6 (
    .CLK(CLK), .RST_N(RST_N), .ENA(ena6), .MODE(mode6), .Sel(sel6),
    .Ch_Mask(mask6), .IN(in6), .OUT_READY(ready6), .OUT_VALID(valid6),
    .Output(out6), .Out_Ch(ch6), .SEL_ERR(err6)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk8(input string tag, input logic v, input logic [7:0] d, input logic [2:0] c);
    chk({tag, ".valid"}, 32'(valid8), 32'(v));
    chk({tag, ".data"},  32'(out8),   32'(d));
    chk({tag, ".ch"},    32'(ch8),    32'(c));
  endtask

  initial begin
    RST_N  = 1'b0;
    ena8 = 0; mode8 = 0; ready8 = 0; sel8 = 0; mask8 = 0;
    ena6 = 0; mode6 = 0; ready6 = 0; sel6 = 0; mask6 = 0;
    for (int i = 0; i < 8; i++) in8[i*8 +: 8] = 8'(8'hA0 + i);
    for (int i = 0; i < 6; i++) in6[i*8 +: 8] = 8'(8'hB0 + i);

    // Reset state
    #3;
    chk8("rst", 1'b0, 8'h00, 3'd0);
    chk("rst.err", 32'(err8), 32'd0);
    RST_N = 1'b1;
    ena8 = 1; ready8 = 1; sel8 = 3'd5;
    #1;
    chk8("pre_edge", 1'b0, 8'h00, 3'd0);

    // Manual capture, 1-cycle latency
    step();
    chk8("man5", 1'b1, 8'hA5, 3'd5);

    // Stall holds the beat while Sel changes
    ready8 = 0; sel8 = 3'd2;
    for (int i = 0; i < 3; i++) begin
      step();
      chk8("stall", 1'b1, 8'hA5, 3'd5);
    end
    ready8 = 1;
    step();
    chk8("man2", 1'b1, 8'hA2, 3'd2);

    // Scan: mode change cycle -> no capture, beat accepted
    mode8 = 1; mask8 = 8'b1000_0101;
    step();
    chk8("mchg", 1'b0, 8'hA2, 3'd2);
    begin
      logic [2:0] seq [8];
      seq = '{3'd0, 3'd0, 3'd2, 3'd2, 3'd7, 3'd7, 3'd0, 3'd0};
      for (int i = 0; i < 8; i++) begin
        step();
        chk8("scan", 1'b1, 8'(8'hA0 + seq[i]), seq[i]);
      end
    end

    // Single set bit: pointer skips hole and sticks on channel 4
    mask8 = 8'b0001_0000;
    for (int i = 0; i < 4; i++) begin
      step();
      chk8("single", 1'b1, 8'hA4, 3'd4);
    end

    // Empty mask: last beat drains, nothing new
    mask8 = 8'b0;
    step();
    chk8("empty0", 1'b0, 8'hA4, 3'd4);
    step();
    chk8("empty1", 1'b0, 8'hA4, 3'd4);

    // Pointer frozen at 4, dwell 0: next set bit above is 7
    mask8 = 8'b1000_0101;
    step();
    chk8("resume", 1'b1, 8'hA7, 3'd7);

    // ENA low: beat drains, no capture, no error
    ena8 = 0;
    step();
    chk8("ena0", 1'b0, 8'hA7, 3'd7);
    chk("ena0.err", 32'(err8), 32'd0);
    ena8 = 1;
    step();
    chk8("dwell2", 1'b1, 8'hA7, 3'd7);

    // Mode toggle mid-scan: two no-capture cycles, then restart at lowest bit
    mode8 = 0; sel8 = 3'd3;
    step();
    chk8("tog0", 1'b0, 8'hA7, 3'd7);
    mode8 = 1; mask8 = 8'b1000_0100;
    step();
    chk8("tog1", 1'b0, 8'hA7, 3'd7);
    step();
    chk8("restart", 1'b1, 8'hA2, 3'd2);

    // Async reset mid-stall
    ready8 = 0;
    step();
    chk8("stall2", 1'b1, 8'hA2, 3'd2);
    #2;
    RST_N = 1'b0;
    #1;
    chk8("async_rst", 1'b0, 8'h00, 3'd0);
    mode8 = 0; ena8 = 0; ready8 = 1;
    #1;
    RST_N = 1'b1;

    // Out-of-range select on the 6-channel instance
    ena6 = 1; ready6 = 1; sel6 = 3'd3;
    step();
    chk("n6.valid", 32'(valid6), 32'd1);
    chk("n6.data",  32'(out6),   32'hB3);
    chk("n6.err",   32'(err6),   32'd0);
    sel6 = 3'd7;
    step();
    chk("oor.err",   32'(err6),   32'd1);
    chk("oor.valid", 32'(valid6), 32'd0);
    chk("oor.data",  32'(out6),   32'hB3);
    chk("oor.ch",    32'(ch6),    32'd3);
    ena6 = 0;
    step();
    chk("oor_ena0.err",   32'(err6),   32'd0);
    chk("oor_ena0.valid", 32'(valid6), 32'd0);
    ena6 = 1; sel6 = 3'd5;
    step();
    chk("n6.top.err",  32'(err6), 32'd0);
    chk("n6.top.data", 32'(out6), 32'hB5);
    chk("n6.top.ch",   32'(ch6),  32'd5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mux_scan_reg.md
Name: mux_scan_reg

Overview:
Parametrised registered N-channel, W-bit multiplexer with enable. It is the successor to the single-bit 8:1 clocked mux.
- Adds a valid/ready output handshake with hold-on-stall.
- Adds an auto-scan mode: channel pointer walks a channel mask with a programmable dwell per channel.
- Adds out-of-range select detection.
Sits between parallel sample sources and a single downstream consumer (serialiser / logger).

Parameters:
NCH, 8, number of input channels (>=2)
W, 8, data width per channel
SELW, $clog2(NCH), select/pointer width (derived, not overridden)
DWELL, 4, captures taken from each channel in scan mode before advancing (>=1)

Ports:
CLK  input  1  clock, rising edge
RST_N  input  1  asynchronous active-low reset
ENA  input  1  capture enable
MODE  input  1  0 = manual select, 1 = auto-scan
Sel  input  SELW  manual channel select
Ch_Mask  input  NCH  scan-mode channel enables (bit i = channel i)
IN  input  NCH*W  channel data; channel i = IN[i*W +: W]
OUT_READY  input  1  downstream accepts beat
OUT_VALID  output  1  Output/Out_Ch hold a valid beat
Output  output  W  captured data
Out_Ch  output  SELW  channel index of captured data
SEL_ERR  output  1  one-cycle pulse: manual Sel >= NCH while capture attempted

Behaviour:
- Reset (RST_N low, async): Output=0, Out_Ch=0, OUT_VALID=0, SEL_ERR=0, ptr=0, dwell=0, mode_q=0. All state updates on posedge CLK after release.
- slot_free = !OUT_VALID || OUT_READY.
- Capture attempt = ENA && slot_free. A successful capture loads Output/Out_Ch and sets OUT_VALID=1 on the same edge; latency is 1 cycle from IN to Output.
- No capture but OUT_READY && OUT_VALID: OUT_VALID->0; Output/Out_Ch keep their last values.
- Stall (OUT_VALID && !OUT_READY): Output, Out_Ch, OUT_VALID, ptr, dwell all held. ENA is ignored.
- ENA low: no capture. A pending beat remains until accepted. Output is never tri-stated.
- Manual (MODE=0):
  - Channel = Sel.
  - Sel < NCH: capture IN[Sel].
  - Sel >= NCH (only possible when NCH is not a power of 2): no capture, SEL_ERR=1 for that cycle, OUT_VALID follows the no-capture rule.
- Scan (MODE=1):
  - Channel = ptr. Capture only if Ch_Mask != 0.
  - If Ch_Mask[ptr]=0 at capture time, first skip ptr to the next set bit (wrap NCH-1 -> 0) and capture that channel in the same cycle.
  - Each capture increments dwell. When dwell reaches DWELL-1 on a capture: dwell->0 and ptr->next set bit above the captured channel, with wrap-around.
  - Single set bit: ptr stays on that channel.
  - Ch_Mask=0: no capture, ptr/dwell hold, SEL_ERR stays 0.
- Mode change: mode_q registers MODE. On the cycle MODE != mode_q, dwell->0 and ptr->0 (the scan restarts from the lowest set bit). No capture occurs that cycle; the output handshake still completes.
- Ch_Mask may change at any time and takes effect on the next capture. Sel is sampled only on capture cycles.
- Reset mid-stall: the beat is discarded and OUT_VALID=0 immediately.

Test Plan:
- Reset/manual: NCH=8, W=8, IN[i]=8'hA0+i. Release RST_N, ENA=1, OUT_READY=1, Sel=5 -> next edge Output=8'hA5, Out_Ch=5, OUT_VALID=1. Before the first edge all outputs are 0.
- Stall: hold OUT_READY=0 for 3 cycles while Sel changes to 2 -> Output stays 8'hA5. OUT_READY=1 -> next edge Output=8'hA2.
- Scan dwell/wrap: MODE=1, DWELL=2, Ch_Mask=8'b1000_0101, OUT_READY=1 -> Out_Ch sequence 0,0,2,2,7,7,0,0.
- Mask holes/empty: Ch_Mask=8'b0001_0000 -> Out_Ch always 4. Ch_Mask=0 -> OUT_VALID drops after the last accepted beat; ptr frozen.
- Out-of-range: NCH=6, Sel=7, ENA=1 -> SEL_ERR pulses 1 cycle, no new beat. ENA=0 cycles -> no captures, no SEL_ERR.
- Async reset mid-stall and mode switch: assert RST_N low between edges with OUT_VALID=1 -> outputs 0 at once. Toggling MODE mid-scan -> one no-capture cycle, then the scan restarts at the lowest mask bit.
